fpu_request_arbiter: RTL and testbench

//  Shares one FPU instance between NUM_REQ independent requesters using round-robin arbitration.

---
 rtl/fpu_request_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_fpu_request_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_request_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_request_arbiter
//
// Shares one FPU between NUM_REQ requesters. A round-robin arbiter accepts one
// operation at a time. The operation is loaded into the FPU with a single-cycle
// FpuLoad pulse. FpuDone is then ignored for a blanking window. The arbiter
// waits for FpuDone or a timeout and returns the result, tagged with the
// requester id, on a valid/ready response port.
//
// Operation sequence: IDLE -> LOAD -> SETTLE -> WAIT -> RESP -> IDLE.
//
// Ports
//   Clk           clock; all state changes on the rising edge
//   Reset         synchronous, active-high; flushes any operation in flight
//   ReqValid      [NUM_REQ]            per-requester request
//   ReqReady      [NUM_REQ]            one-hot accept (IDLE only, combinational)
//   ReqA / ReqB   [NUM_REQ*PRECISION]  operands, requester i at [i*PRECISION +: PRECISION]
//   ReqOperation  [2*NUM_REQ]          op code per requester: 00 add, 01 sub, 10 mul, 11 div
//   RespValid     response available (RESP state)
//   RespReady     response consumer ready
//   RespId        [ID_W]               index of the serviced requester
//   RespResult    [PRECISION]          FPU result, 0 on timeout
//   RespTimeout   response is an abort rather than a result
//   FpuA / FpuB   [PRECISION]          operands to the FPU, held for the whole operation
//   FpuOperation  [2]                  op code to the FPU, held for the whole operation
//   FpuLoad       one-cycle load pulse; drives the FPU Reset/load pin
//   FpuResult     [PRECISION]          FPU result
//   FpuDone       FPU done
//   Busy          high in every state except IDLE
// ----------------------------------------------------------------------------
module fpu_request_arbiter #(
    parameter int PRECISION      = 32,
    parameter int NUM_REQ        = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [NUM_REQ-1:0]           ReqValid,
    output logic [NUM_REQ-1:0]           ReqReady,
    input  logic [NUM_REQ*PRECISION-1:0] ReqA,
    input  logic [NUM_REQ*PRECISION-1:0] ReqB,
    input  logic [2*NUM_REQ-1:0]         ReqOperation,
    output logic                         RespValid,
    input  logic                         RespReady,
    output logic [ID_W-1:0]              RespId,
    output logic [PRECISION-1:0]         RespResult,
    output logic                         RespTimeout,
    output logic [PRECISION-1:0]         FpuA,
    output logic [PRECISION-1:0]         FpuB,
    output logic [1:0]                   FpuOperation,
    output logic                         FpuLoad,
    input  logic [PRECISION-1:0]         FpuResult,
    input  logic                         FpuDone,
    output logic                         Busy
);

    // One counter serves both the settle window and the wait timeout.
    // It is therefore sized for the longer of the two.
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [ID_W-1:0]      ptr_q,   ptr_d;
    logic [ID_W-1:0]      id_q,    id_d;
    logic [PRECISION-1:0] a_q,     a_d;
    logic [PRECISION-1:0] b_q,     b_d;
    logic [1:0]           op_q,    op_d;
    logic [PRECISION-1:0] res_q,   res_d;
    logic                 to_q,    to_d;

    logic                 grant_vld;
    logic [ID_W-1:0]      grant_id;
    logic                 accept;
    logic                 wait_end;
    logic                 resp_hs;

    // ------------------------------------------------------------------------
    // Round-robin pick: the first valid index at or after ptr_q, wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_vld && ReqValid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    // Reset masks the grant so that no transfer appears to complete in a
    // cycle whose effects are about to be flushed.
    assign accept   = (state_q == S_IDLE) && grant_vld && !Reset;
    // The final timeout cycle ends WAIT as well. If FpuDone is also high in
    // that cycle, the result wins.
    assign wait_end = (state_q == S_WAIT) && (FpuDone || (cnt_q == TIMEOUT_LAST));
    assign resp_hs  = (state_q == S_RESP) && RespReady;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_vld) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // FpuDone is not looked at here: it is invalid while the FPU
                // is blanking after load.
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_end) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (RespReady) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        ReqReady = '0;
        if (accept) begin
            ReqReady[grant_id] = 1'b1;
        end
        FpuLoad   = (state_q == S_LOAD);
        RespValid = (state_q == S_RESP);
        Busy      = (state_q != S_IDLE);
    end

    // ------------------------------------------------------------------------
    // Operation and response registers: next-state
    // ------------------------------------------------------------------------
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        id_d  = id_q;
        res_d = res_q;
        to_d  = to_q;
        ptr_d = ptr_q;

        if (accept) begin
            a_d  = ReqA[int'(grant_id)*PRECISION +: PRECISION];
            b_d  = ReqB[int'(grant_id)*PRECISION +: PRECISION];
            op_d = ReqOperation[int'(grant_id)*2 +: 2];
            id_d = grant_id;
        end

        if (wait_end) begin
            if (FpuDone) begin
                res_d = FpuResult;
                to_d  = 1'b0;
            end else begin
                res_d = '0;
                to_d  = 1'b1;
            end
        end

        // The requester just served drops to lowest priority.
        if (resp_hs) begin
            ptr_d = ID_W'((int'(id_q) + 1) % NUM_REQ);
        end
    end

    // ------------------------------------------------------------------------
    // Operation and response registers: storage
    // All of these are visible on outputs, so reset clears them as well.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            id_q  <= '0;
            res_q <= '0;
            to_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            id_q  <= id_d;
            res_q <= res_d;
            to_q  <= to_d;
            ptr_q <= ptr_d;
        end
    end

    assign FpuA         = a_q;
    assign FpuB         = b_q;
    assign FpuOperation = op_q;
    assign RespId       = id_q;
    assign RespResult   = res_q;
    assign RespTimeout  = to_q;

endmodule

// File: tb/tb_fpu_request_arbiter.sv
module tb_fpu_request_arbiter;
    localparam int P      = 32;
    localparam int N      = 4;
    localparam int SETTLE = 2;
    localparam int TMO    = 64;
    localparam int ID_W   = 2;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [N-1:0]     ReqValid = '0;
    logic [N-1:0]     ReqReady;
    logic [N*P-1:0]   ReqA = '0;
    logic [N*P-1:0]   ReqB = '0;
    logic [2*N-1:0]   ReqOperation = '0;
    logic             RespValid;
    logic             RespReady = 1'b1;
    logic [ID_W-1:0]  RespId;
    logic [P-1:0]     RespResult;
    logic             RespTimeout;
    logic [P-1:0]     FpuA, FpuB;
    logic [1:0]       FpuOperation;
    logic             FpuLoad;
    logic [P-1:0]     FpuResult = '0;
    logic             FpuDone = 1'b0;
    logic             Busy;

    fpu_request_arbiter #(
        .PRECISION(P), .NUM_REQ(N), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqA(ReqA), .ReqB(ReqB), .ReqOperation(ReqOperation),
        .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
        .RespResult(RespResult), .RespTimeout(RespTimeout),
        .FpuA(FpuA), .FpuB(FpuB), .FpuOperation(FpuOperation), .FpuLoad(FpuLoad),
        .FpuResult(FpuResult), .FpuDone(FpuDone), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural FPU stand-in: returns known IEEE results for the directed
    // vectors and a scrambled value for anything else.
    function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (a == 32'h3FC00000 && b == 32'h40100000 && op == 2'b00) return 32'h40700000;
        if (a == 32'h40000000 && b == 32'h40400000 && op == 2'b10) return 32'h40C00000;
        if (a == 32'h3F800000 && b == 32'h40800000 && op == 2'b11) return 32'h3E800000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    // ---------------- FPU model ----------------
    int           fpu_lat = 3;     // cycles after the load cycle until Done
    bit           fpu_hang = 1'b0;
    bit           fpu_early = 1'b0;  // spurious Done during blanking
    bit           fpu_act = 1'b0;
    bit           load_seen = 1'b0;
    int           fpu_c = 0;
    logic [31:0]  fa = '0, fb = '0;
    logic [1:0]   fop = '0;

    always @(negedge Clk) begin
        if (FpuLoad) begin
            load_seen = 1'b1;
            fa = FpuA; fb = FpuB; fop = FpuOperation;
        end
    end

    always @(posedge Clk) begin
        #2;
        if (load_seen) begin
            load_seen = 1'b0; fpu_act = 1'b1; fpu_c = 1;
        end else if (fpu_act) begin
            fpu_c++;
        end
        FpuDone   = 1'b0;
        FpuResult = 32'hDEADBEEF;
        if (fpu_act) begin
            if (fpu_early && (fpu_c == 1 || fpu_c == 2)) FpuDone = 1'b1;
            if (!fpu_hang && fpu_c == fpu_lat) begin
                FpuDone = 1'b1;
                FpuResult = fpu_ref(fa, fb, fop);
                fpu_act = 1'b0;
            end
        end
    end

    // ---------------- Requesters drop ReqValid once accepted ----------------
    bit           auto_drop = 1'b1;
    logic [N-1:0] drop_n = '0;
    always @(negedge Clk) drop_n = ReqReady & ReqValid;
    always @(posedge Clk) begin
        #1;
        if (auto_drop) ReqValid = ReqValid & ~drop_n;
        drop_n = '0;
    end

    // ---------------- Reference model ----------------
    // Tracks an operation by the number of cycles since it was accepted:
    // cycle 1 is the load, the next SETTLE cycles are blanking, and from then
    // on Done (or the TMO-th waiting cycle) produces the response.
    bit          m_busy = 0, m_resp = 0, m_to = 0;
    int          m_k = 0, m_ptr = 0, m_id = 0;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [1:0]  m_op = 0;

    function automatic void pick(input logic [N-1:0] v, input int ptr, output bit f, output int id);
        int j;
        f = 1'b0; id = 0;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (!f && v[j]) begin f = 1'b1; id = j; end
        end
    endfunction

    always @(posedge Clk) begin : model
        bit f; int g; int w;
        cyc++;
        pick(ReqValid, m_ptr, f, g);
        if (Reset) begin
            m_busy = 0; m_resp = 0; m_to = 0; m_k = 0; m_ptr = 0; m_id = 0;
            m_a = 0; m_b = 0; m_res = 0; m_op = 0;
        end else if (!m_busy) begin
            if (f) begin
                m_busy = 1; m_k = 1; m_id = g;
                m_a = ReqA[g*P +: P]; m_b = ReqB[g*P +: P]; m_op = ReqOperation[g*2 +: 2];
            end
        end else if (!m_resp) begin
            if (m_k >= 2 + SETTLE) begin
                w = m_k - (2 + SETTLE);
                if (FpuDone) begin
                    m_resp = 1; m_res = FpuResult; m_to = 0;
                end else if (w == TMO - 1) begin
                    m_resp = 1; m_res = 0; m_to = 1;
                end
            end
            m_k++;
        end else if (RespReady) begin
            m_busy = 0; m_resp = 0; m_ptr = (m_id + 1) % N;
        end
    end

    // ---------------- Per-cycle compare and event log ----------------
    logic [ID_W-1:0] hs_id[$];
    logic [31:0]     hs_res[$];
    bit              hs_to[$];
    int              hs_cyc[$];
    int              acc_cyc[$];
    int              rv_cyc[$];
    int              n_load = 0;
    bit              rv_prev = 0;

    always @(negedge Clk) begin : cmp
        bit f; int g; logic [N-1:0] exp_rr;
        pick(ReqValid, m_ptr, f, g);
        exp_rr = '0;
        if (!m_busy && !Reset && f) exp_rr[g] = 1'b1;
        chk("ReqReady", ReqReady, exp_rr);
        chk("ReqReady_onehot", $onehot0(ReqReady), 1);
        chk("Busy", Busy, m_busy);
        chk("RespValid", RespValid, m_busy && m_resp);
        chk("FpuLoad", FpuLoad, m_busy && m_k == 1);
        chk("RespId", RespId, m_id);
        chk("RespResult", RespResult, m_res);
        chk("RespTimeout", RespTimeout, m_to);
        chk("FpuA", FpuA, m_a);
        chk("FpuB", FpuB, m_b);
        chk("FpuOperation", FpuOperation, m_op);
        if (RespValid && RespReady) begin
            hs_id.push_back(RespId); hs_res.push_back(RespResult);
            hs_to.push_back(RespTimeout); hs_cyc.push_back(cyc);
        end
        if (|ReqReady) acc_cyc.push_back(cyc);
        if (FpuLoad) n_load++;
        if (RespValid && !rv_prev) rv_cyc.push_back(cyc);
        rv_prev = RespValid;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk); #2;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        ReqA[i*P +: P] = a;
        ReqB[i*P +: P] = b;
        ReqOperation[i*2 +: 2] = op;
        ReqValid[i] = 1'b1;
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int t = 0;
        while (hs_id.size() < n && t < budget) begin
            @(negedge Clk); #1; t++;
        end
        chk(name, hs_id.size() >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int b, t, c0, cr;
        logic [ID_W-1:0] sid; logic [31:0] sres; bit sto;

        repeat (3) tick();
        Reset = 1'b0;
        @(negedge Clk); #1;
        chk("rst_busy", Busy, 0);
        chk("rst_respvalid", RespValid, 0);
        chk("rst_result", RespResult, 0);
        chk("rst_fpuload", FpuLoad, 0);
        chk("rst_reqready", ReqReady, 0);

        // T1: single add from requester 0
        tick();
        set_req(0, 32'h3FC00000, 32'h40100000, 2'b00);
        wait_hs(1, 40, "t1_wait");
        chk("t1_id", hs_id[0], 0);
        chk("t1_result", hs_res[0], 32'h40700000);
        chk("t1_timeout", hs_to[0], 0);
        chk("t1_loads", n_load, 1);
        chk("t1_latency", rv_cyc[0] - acc_cyc[0], 5);

        // T2: requesters 2 and 3 together; pointer is 1 so 2 goes first
        tick();
        set_req(2, 32'h40000000, 32'h40400000, 2'b10);
        set_req(3, 32'h3F800000, 32'h40800000, 2'b11);
        b = hs_id.size();
        wait_hs(b + 2, 80, "t2_wait");
        chk("t2_id0", hs_id[b], 2);
        chk("t2_res0", hs_res[b], 32'h40C00000);
        chk("t2_id1", hs_id[b+1], 3);
        chk("t2_res1", hs_res[b+1], 32'h3E800000);

        // T3: all four held high for five operations
        tick();
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++)
            set_req(i, 32'h3F000000 + i, 32'h41000000 + 16*i, 2'(i));
        b = hs_id.size();
        wait_hs(b + 5, 200, "t3_wait");
        tick();
        ReqValid = '0;
        auto_drop = 1'b1;
        chk("t3_g0", hs_id[b], 0);
        chk("t3_g1", hs_id[b+1], 1);
        chk("t3_g2", hs_id[b+2], 2);
        chk("t3_g3", hs_id[b+3], 3);
        chk("t3_g4", hs_id[b+4], 0);

        // T4: FPU never finishes, spurious Done during blanking
        fpu_hang = 1'b1; fpu_early = 1'b1;
        tick();
        set_req(1, 32'h12345678, 32'h9ABCDEF0, 2'b01);
        b = hs_id.size();
        wait_hs(b + 1, 120, "t4_wait");
        chk("t4_id", hs_id[b], 1);
        chk("t4_timeout", hs_to[b], 1);
        chk("t4_result", hs_res[b], 0);
        chk("t4_latency", rv_cyc[rv_cyc.size()-1] - acc_cyc[acc_cyc.size()-1], 68);
        fpu_hang = 1'b0; fpu_early = 1'b0;

        // T5: response backpressure for 10 cycles
        tick();
        RespReady = 1'b0;
        set_req(2, 32'h40000000, 32'h40400000, 2'b10);
        t = 0;
        while (!RespValid && t < 40) begin @(negedge Clk); #1; t++; end
        chk("t5_respvalid", RespValid, 1);
        sid = RespId; sres = RespResult; sto = RespTimeout;
        chk("t5_res", sres, 32'h40C00000);
        tick();
        set_req(0, 32'h3FC00000, 32'h40100000, 2'b00);
        b = hs_id.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk); #1;
            chk("t5_hold_valid", RespValid, 1);
            chk("t5_hold_id", RespId, sid);
            chk("t5_hold_res", RespResult, sres);
            chk("t5_hold_to", RespTimeout, sto);
            chk("t5_hold_ready", ReqReady, 0);
            if (i < 9) tick();
        end
        tick();
        RespReady = 1'b1;
        cr = cyc;
        wait_hs(b + 1, 5, "t5_accept");
        chk("t5_accept_cycle", hs_cyc[b], cr);
        wait_hs(b + 2, 40, "t5_next");
        chk("t5_next_id", hs_id[b+1], 0);

        // T6: reset during WAIT flushes the operation and the pointer
        fpu_lat = 20;
        tick();
        set_req(3, 32'h11111111, 32'h22222222, 2'b00);
        c0 = acc_cyc.size();
        t = 0;
        while (acc_cyc.size() == c0 && t < 20) begin @(negedge Clk); #1; t++; end
        chk("t6_accept", acc_cyc.size() > c0, 1);
        repeat (5) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clk); #1;
        chk("t6_busy", Busy, 0);
        chk("t6_respvalid", RespValid, 0);
        chk("t6_result", RespResult, 0);
        chk("t6_id", RespId, 0);
        chk("t6_fpua", FpuA, 0);
        b = hs_id.size();
        t = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (RespValid) t++;
        end
        chk("t6_no_resp", t, 0);
        chk("t6_no_hs", hs_id.size(), b);
        fpu_lat = 3;
        set_req(0, 32'h3FC00000, 32'h40100000, 2'b00);
        set_req(3, 32'h3F800000, 32'h40800000, 2'b11);
        wait_hs(b + 2, 80, "t6_wait");
        chk("t6_ptr_first", hs_id[b], 0);
        chk("t6_res_first", hs_res[b], 32'h40700000);
        chk("t6_second", hs_id[b+1], 3);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
